// File: rtl/mod_n_step_counter_pkg.sv
// Shared definitions for the modulo-N step counter: synchroniser depth and
// the load clamping helper.
package ctr_pkg;

  // Number of flops in the metastability synchroniser on the raw step input.
  localparam int SYNC_STAGES = 2;

  // Clamp a load value into the legal count range 0..modulus-1.
  function automatic int unsigned clamp_mod(input int unsigned val,
                                            input int unsigned modulus);
    if (val >= modulus) return modulus - 1;
    else return val;
  endfunction

endpackage

// File: rtl/mod_n_step_counter_step_edge_detect.sv
// Brings the raw step level into the clk domain and turns each rising edge
// of it into a single-cycle step pulse.
module step_edge_detect
  import ctr_pkg::*;
#(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic step_in,
  output logic step_pulse
);

  logic sync_out;
  logic prev_q;

  if (SYNC_EN) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Multi-flop synchroniser for an input asynchronous to clk.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], step_in};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
  end else begin : g_nosync
    logic in_q;

    // Input is already synchronous; one register keeps the pulse glitch-free.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) in_q <= 1'b0;
      else        in_q <= step_in;
    end

    assign sync_out = in_q;
  end

  // Previous synchronised level, cleared by reset so a level held through
  // reset release still produces one pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= sync_out;
  end

  assign step_pulse = sync_out & ~prev_q;

endmodule

// File: rtl/mod_n_step_counter.sv
// Synchronous modulo-MODULUS up/down event counter with clear, clamped load,
// a terminal-count pulse and a toggle-on-wrap status output.
module mod_n_step_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_tgl
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_step_counter: MODULUS=%0d outside 2..2**WIDTH (WIDTH=%0d)",
           MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   CNT_LIM = (WIDTH + 1)'(MODULUS);

  logic             step_pulse;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   dec_x;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             tgl_nxt;

  step_edge_detect #(
    .SYNC_EN (SYNC_EN)
  ) u_step_edge_detect (
    .clk        (clk),
    .reset      (reset),
    .step_in    (step_in),
    .step_pulse (step_pulse)
  );

  // One extra bit: reaching MODULUS on increment, or a borrow on decrement,
  // marks the wrap without a separate comparator against 0.
  assign inc_x = {1'b0, count} + (WIDTH + 1)'(1);
  assign dec_x = {1'b0, count} - (WIDTH + 1)'(1);

  // Next-state selection: clr beats load beats an enabled step; anything
  // not taken that cycle is dropped rather than deferred.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    tgl_nxt   = wrap_tgl;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = WIDTH'(clamp_mod(32'(load_val), MODULUS));
    end else if (step_pulse && en) begin
      if (up_dn) begin
        if (inc_x == CNT_LIM) begin
          count_nxt = '0;
          tc_nxt    = 1'b1;
          tgl_nxt   = ~wrap_tgl;
        end else begin
          count_nxt = inc_x[WIDTH-1:0];
        end
      end else begin
        if (dec_x[WIDTH]) begin
          count_nxt = CNT_MAX;
          tc_nxt    = 1'b1;
          tgl_nxt   = ~wrap_tgl;
        end else begin
          count_nxt = dec_x[WIDTH-1:0];
        end
      end
    end
  end

  // Registered count, terminal-count pulse and wrap toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      tc       <= 1'b0;
      wrap_tgl <= 1'b0;
    end else begin
      count    <= count_nxt;
      tc       <= tc_nxt;
      wrap_tgl <= tgl_nxt;
    end
  end

endmodule
